// File: rtl/beam_trig_stretch_scaler_pkg.sv
// Shared constants and address helper for the beam trigger stretcher/scaler.
package beam_trig_stretch_scaler_pkg;

  localparam int BTS_NBEAMS       = 54;
  localparam int BTS_NLEVELS      = 2;
  localparam int BTS_STRETCH_BITS = 4;
  localparam int BTS_SCAL_BITS    = 16;

  // Flat scaler readout index: levels are laid out one after another.
  function automatic int unsigned scal_adr(input int unsigned level,
                                           input int unsigned beam,
                                           input int unsigned nbeams);
    return level * nbeams + beam;
  endfunction

endpackage

// File: rtl/trig_stretch_chan.sv
// One (level,beam) channel: non-retriggerable pulse stretcher plus a
// saturating live scaler with a per-period latched copy.
module trig_stretch_chan #(
  parameter int STRETCH_BITS = 4,
  parameter int SCAL_BITS    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    trig_i,
  input  logic                    mask_i,
  input  logic [STRETCH_BITS-1:0] stretch_len_i,
  input  logic                    timer_i,
  output logic                    trig_o,
  output logic [SCAL_BITS-1:0]    latch_o
);

  logic [STRETCH_BITS-1:0] cnt;
  logic [SCAL_BITS-1:0]    live;
  logic                    start;

  function automatic logic [SCAL_BITS-1:0] sat_inc(input logic [SCAL_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A stretch may only begin from a fully idle channel that is not masked.
  assign start = trig_i & ~mask_i & ~trig_o & (cnt == '0);

  // Stretcher: output held for stretch_len+1 cycles, length captured at start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      trig_o <= 1'b0;
    end else if (mask_i) begin
      cnt    <= '0;
      trig_o <= 1'b0;
    end else if (start) begin
      cnt    <= stretch_len_i;
      trig_o <= 1'b1;
    end else if (trig_o) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      else           trig_o <= 1'b0;
    end
  end

  // Scaler: a start coincident with the period end counts in the new period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live    <= '0;
      latch_o <= '0;
    end else if (timer_i) begin
      latch_o <= live;
      live    <= {{(SCAL_BITS-1){1'b0}}, start};
    end else if (start) begin
      live    <= sat_inc(live);
    end
  end

endmodule

// File: rtl/beam_trig_stretch_scaler.sv
// Top: per-channel stretchers/scalers, period bookkeeping and scaler readout.
module beam_trig_stretch_scaler
  import beam_trig_stretch_scaler_pkg::*;
#(
  parameter int NBEAMS       = BTS_NBEAMS,
  parameter int NLEVELS      = BTS_NLEVELS,
  parameter int STRETCH_BITS = BTS_STRETCH_BITS,
  parameter int SCAL_BITS    = BTS_SCAL_BITS
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NLEVELS-1:0][NBEAMS-1:0]      trig_i,
  input  logic [NBEAMS-1:0]                   mask_i,
  input  logic [STRETCH_BITS-1:0]             stretch_len_i,
  input  logic                                timer_i,
  input  logic [$clog2(NLEVELS*NBEAMS)-1:0]   rd_adr_i,
  output logic [NLEVELS-1:0][NBEAMS-1:0]      trig_o,
  output logic [SCAL_BITS-1:0]                rd_dat_o,
  output logic                                bank_o,
  output logic                                done_o
);

  localparam int NCH = NLEVELS * NBEAMS;
  localparam int AW  = $clog2(NCH);
  localparam logic [AW:0] NCH_W = (AW+1)'(NCH);

  logic                 armed;
  logic                 timer_go;
  logic [SCAL_BITS-1:0] latch_q [NCH];

  // The edge that releases reset must not close a period.
  assign timer_go = timer_i & armed;

  for (genvar l = 0; l < NLEVELS; l++) begin : g_lvl
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
      localparam int unsigned IDX = scal_adr(l, b, NBEAMS);
      trig_stretch_chan #(
        .STRETCH_BITS (STRETCH_BITS),
        .SCAL_BITS    (SCAL_BITS)
      ) u_chan (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .trig_i        (trig_i[l][b]),
        .mask_i        (mask_i[b]),
        .stretch_len_i (stretch_len_i),
        .timer_i       (timer_go),
        .trig_o        (trig_o[l][b]),
        .latch_o       (latch_q[IDX])
      );
    end
  end

  // Arms timer handling from the second edge after reset release onward.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // Period-end flags: bank flips and done pulses one cycle after the timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= timer_go;
      if (timer_go) bank_o <= ~bank_o;
    end
  end

  // Registered readout of the latched scalers; unused addresses read zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          rd_dat_o <= '0;
    else if ({1'b0, rd_adr_i} < NCH_W)  rd_dat_o <= latch_q[rd_adr_i];
    else                                rd_dat_o <= '0;
  end

endmodule

// File: doc/beam_trig_stretch_scaler.md
BEAM_TRIG_STRETCH_SCALER -- requirements
Module: beam_trig_stretch_scaler

Interface
REQ-001 Parameter NBEAMS, default 54, beam count per level.
REQ-002 Parameter NLEVELS, default 2, trigger levels (0 = real, 1..NLEVELS-1 = subthresholds).
REQ-003 Parameter STRETCH_BITS, default 4, width of stretch length.
REQ-004 Parameter SCAL_BITS, default 16, scaler counter width.
REQ-005 clk_i  in  1  sole clock; all logic single-domain.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 trig_i  in  [NLEVELS][NBEAMS]  raw per-cycle trigger bits.
REQ-008 mask_i  in  NBEAMS  1 = beam disabled on all levels.
REQ-009 stretch_len_i  in  STRETCH_BITS  extra stretch cycles.
REQ-010 timer_i  in  1  single-cycle pulse ending a scaler period.
REQ-011 rd_adr_i  in  clog2(NLEVELS*NBEAMS)  scaler readout index = level*NBEAMS+beam.
REQ-012 trig_o  out  [NLEVELS][NBEAMS]  stretched triggers.
REQ-013 rd_dat_o  out  SCAL_BITS  latched scaler value at rd_adr_i.
REQ-014 bank_o  out  1  toggles at each completed period.
REQ-015 done_o  out  1  one-cycle pulse when new latched values are valid.

Function
REQ-016 Each (level,beam) channel shall hold a STRETCH_BITS down-counter; channel is "idle" when it is zero and trig_o is low.
REQ-017 An idle, unmasked channel with trig_i high shall start a stretch: trig_o goes high the next cycle and stays high exactly stretch_len_i+1 cycles (stretch_len_i sampled at start).
REQ-018 trig_i high while the channel is stretching shall be ignored (non-retriggerable): no extension, no count.
REQ-019 trig_i held high continuously shall produce back-to-back stretches, with each stretch start one cycle after the previous one ends (trig_o low for one cycle between).
REQ-020 Each stretch start shall increment that channel's live scaler by 1, saturating at 2^SCAL_BITS-1.
REQ-021 mask_i high for a beam shall force trig_o low on every level from the next cycle, abort any active stretch and block counting; deasserting it makes the channel idle.
REQ-022 On timer_i, every live scaler shall copy into its latched register and the live scaler shall restart at 0, or at 1 if a stretch starts that same cycle (the start belongs to the new period).
REQ-023 bank_o shall toggle and done_o pulse high exactly one cycle after timer_i.
REQ-024 A timer_i pulse arriving while done_o is high shall be processed normally (minimum period 1 cycle).
REQ-025 rd_dat_o shall present the latched value at rd_adr_i with one-cycle registered latency; out-of-range addresses return 0.
REQ-026 Changing stretch_len_i mid-stretch shall not alter the active stretch.

Reset
REQ-027 rst_i shall asynchronously clear all stretch counters, live and latched scalers, trig_o, rd_dat_o, bank_o and done_o to 0.
REQ-028 After rst_i deasserts, the first clock edge with trig_i high shall start stretches normally; a timer_i coincident with the release edge is ignored.

Structure
REQ-029 Shared package shall hold the default NBEAMS/NLEVELS/STRETCH_BITS/SCAL_BITS constants and the readout-index helper (level,beam → address).
REQ-030 One sub-module, trig_stretch_chan (one counter+scaler channel), shall be generated NLEVELS*NBEAMS times; top holds the timer/bank/readout logic.

Verification
REQ-031 stretch_len=3, single-cycle trig_i on L0 beam 5 at cycle 10 -> trig_o[0][5] high cycles 11–14; scaler reads 1 after timer.
REQ-032 stretch_len=2, trig_i L1 beam 0 held high 12 cycles -> trig_o pattern 3 high/1 low repeated, 3 starts counted.
REQ-033 Trigger start coincident with timer_i -> latched value excludes it; next period reads 1; done_o at timer+1, bank_o toggles.
REQ-034 SCAL_BITS=4, 20 stretch starts in one period -> latched value 15.
REQ-035 mask_i[7] asserted mid-stretch -> trig_o[*][7] low next cycle, further triggers uncounted; deassert -> normal stretch on next trig_i.
REQ-036 rst_i pulsed mid-stretch with nonzero scalers -> all outputs 0 immediately, rd_dat_o of every address reads 0 afterward.
